keyscan_evq: RTL and testbench

Parametrised key-matrix scanner with per-key hysteresis debounce and a press/release event queue, exposed as a Wishbone slave. It drives one active-low row at a time, samples active-low columns, and keeps a debounced state per key. A sweep engine compares debounced state against last-reported state and pushes one event per change into a FIFO. The FIFO is drained by CPU reads, with an optional level interrupt, so firmware no longer polls raw row bitmaps.

---
 rtl/keyscan_evq.sv | 219 +++++++++++++++++++++
 tb/tb_keyscan_evq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keyscan_evq.sv
// Key-matrix scanner: rotating active-low row drive, per-key hysteresis debounce,
// and a sweep engine that queues press/release events for a Wishbone reader.
module keyscan_evq #(
  parameter int N_ROWS     = 4,
  parameter int N_COLS     = 12,
  parameter int DIV_W      = 14,
  parameter int DEB_W      = 5,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_COLS-1:0] km_col,
  output logic [N_ROWS-1:0] km_row,
  input  logic [3:0]        wb_addr,
  output logic [31:0]       wb_rdata,
  input  logic [31:0]       wb_wdata,
  input  logic              wb_we,
  input  logic              wb_cyc,
  output logic              wb_ack,
  output logic              irq
);

  localparam int N_KEYS = N_ROWS * N_COLS;
  localparam int KW     = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW     = $clog2(FIFO_DEPTH + 1);

  logic              scan_en_reg, evt_en_reg, irq_en_reg;
  logic [DIV_W-1:0]  div_reg;
  logic [2:0]        row_reg;
  logic              strobe;
  logic [N_KEYS-1:0] deb;
  logic [N_KEYS-1:0] rep_reg;
  logic [KW-1:0]     k_reg;
  logic [2:0]        sw_row_reg;
  logic [4:0]        sw_col_reg;
  logic [8:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]     level_reg;
  logic              stall_reg;
  logic              ack_reg, evt_rd_reg, irq_reg;
  logic [31:0]       rdata_reg;

  logic              full, empty, mismatch, push, pop, advance;
  logic              wb_req, wr_commit;
  logic [8:0]        entry, head;
  logic [31:0]       rd_mux;
  logic [7:0][31:0]  row_word;
  logic              unused_wdata;

  assign unused_wdata = ^{wb_wdata[31:25], wb_wdata[23:3]};

  assign strobe = scan_en_reg && (div_reg == '1);

  // Divider and row pointer restart from row 0 whenever scanning is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg <= '0;
      row_reg <= '0;
    end else if (!scan_en_reg) begin
      div_reg <= '0;
      row_reg <= '0;
    end else begin
      div_reg <= div_reg + DIV_W'(1);
      if (strobe)
        row_reg <= (row_reg == 3'(N_ROWS - 1)) ? 3'd0 : row_reg + 3'd1;
    end
  end

  for (genvar gi = 0; gi < N_ROWS; gi++) begin : g_row
    assign km_row[gi] = ~(scan_en_reg && (row_reg == 3'(gi)));
  end

  // Hysteresis: a closed sample reloads all ones; the MSB stays set for
  // 2^(DEB_W-1) open samples before the key counts as released.
  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
    localparam int R = gi / N_COLS;
    localparam int C = gi % N_COLS;
    logic [DEB_W-1:0] cnt_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        cnt_reg <= '0;
      else if (strobe && (row_reg == 3'(R))) begin
        if (!km_col[C])
          cnt_reg <= '1;
        else if (cnt_reg[DEB_W-1])
          cnt_reg <= cnt_reg - DEB_W'(1);
        else
          cnt_reg <= '0;
      end
    end
    assign deb[gi] = cnt_reg[DEB_W-1];
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_rword
    if (gi < N_ROWS) begin : g_used
      assign row_word[gi] = 32'(deb[gi*N_COLS +: N_COLS]);
    end else begin : g_zero
      assign row_word[gi] = '0;
    end
  end

  assign full     = (level_reg == LW'(FIFO_DEPTH));
  assign empty    = (level_reg == '0);
  assign mismatch = evt_en_reg && (deb[k_reg] != rep_reg[k_reg]);
  assign push     = mismatch && !full;
  // A mismatch that cannot be queued parks the sweep on that key.
  assign advance  = evt_en_reg && !(mismatch && full);
  assign entry    = {deb[k_reg], sw_row_reg, sw_col_reg};
  assign head     = mem[rd_ptr_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rep_reg <= '0;
    else if (!evt_en_reg)
      rep_reg <= deb;
    else if (push)
      rep_reg[k_reg] <= deb[k_reg];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_reg      <= '0;
      sw_row_reg <= '0;
      sw_col_reg <= '0;
    end else if (advance) begin
      if (k_reg == KW'(N_KEYS - 1)) begin
        k_reg      <= '0;
        sw_row_reg <= '0;
        sw_col_reg <= '0;
      end else begin
        k_reg <= k_reg + KW'(1);
        if (sw_col_reg == 5'(N_COLS - 1)) begin
          sw_col_reg <= '0;
          sw_row_reg <= sw_row_reg + 3'd1;
        end else begin
          sw_col_reg <= sw_col_reg + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= (wr_ptr_reg == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + AW'(1);
      if (pop)
        rd_ptr_reg <= (rd_ptr_reg == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  assign wb_req    = wb_cyc && !ack_reg;
  assign wr_commit = ack_reg && wb_cyc && wb_we;
  // Pop only if the ack cycle actually returned a valid event.
  assign pop       = ack_reg && evt_rd_reg;

  always_comb begin
    rd_mux = '0;
    case (wb_addr)
      4'd0: rd_mux = {29'd0, irq_en_reg, evt_en_reg, scan_en_reg};
      4'd1: rd_mux = {7'd0, stall_reg, 6'd0, full, empty, 7'd0, 9'(level_reg)};
      4'd2: if (!empty)
              rd_mux = {1'b1, 14'd0, head[8], 5'd0, head[7:5], 3'd0, head[4:0]};
      default: if (wb_addr[3]) rd_mux = row_word[wb_addr[2:0]];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_reg    <= 1'b0;
      evt_rd_reg <= 1'b0;
      rdata_reg  <= '0;
      irq_reg    <= 1'b0;
    end else begin
      ack_reg    <= wb_req;
      evt_rd_reg <= wb_req && !wb_we && (wb_addr == 4'd2) && !empty;
      rdata_reg  <= (wb_req && !wb_we) ? rd_mux : '0;
      irq_reg    <= irq_en_reg && !empty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_en_reg <= 1'b1;
      evt_en_reg  <= 1'b0;
      irq_en_reg  <= 1'b0;
      stall_reg   <= 1'b0;
    end else begin
      if (wr_commit && (wb_addr == 4'd0)) begin
        scan_en_reg <= wb_wdata[0];
        evt_en_reg  <= wb_wdata[1];
        irq_en_reg  <= wb_wdata[2];
      end
      if (mismatch && full)
        stall_reg <= 1'b1;
      else if (wr_commit && (wb_addr == 4'd1) && wb_wdata[24])
        stall_reg <= 1'b0;
    end
  end

  assign wb_ack   = ack_reg;
  assign wb_rdata = rdata_reg;
  assign irq      = irq_reg;

endmodule

// File: tb/tb_keyscan_evq.sv
// Randomised bench for keyscan_evq: a per-key debounce/event model driven by the
// same key matrix; events are matched per key against the model's transition list.
module tb_keyscan_evq;
  localparam int NR = 4, NC = 12, DW = 4, DBW = 5, FD = 4, NK = NR * NC;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [NC-1:0] km_col;
  logic [NR-1:0] km_row;
  logic [3:0]    wb_addr = '0;
  logic [31:0]   wb_rdata, wb_wdata = '0;
  logic          wb_we = 1'b0, wb_cyc = 1'b0, wb_ack, irq;

  always #5 clk = ~clk;

  keyscan_evq #(.N_ROWS(NR), .N_COLS(NC), .DIV_W(DW), .DEB_W(DBW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .km_col(km_col), .km_row(km_row),
    .wb_addr(wb_addr), .wb_rdata(wb_rdata), .wb_wdata(wb_wdata), .wb_we(wb_we),
    .wb_cyc(wb_cyc), .wb_ack(wb_ack), .irq(irq)
  );

  logic [NC-1:0] keys [NR];
  always_comb begin
    km_col = '1;
    for (int r = 0; r < NR; r++)
      if (!km_row[r]) km_col = km_col & ~keys[r];
  end

  int n_checks = 0, n_errors = 0, n_press = 0, n_rel = 0;
  bit deb_m [NK];
  int open_run [NK];
  int md, mr;
  bit m_scan = 1'b1, m_evt = 1'b0;
  int exp_key [$];
  bit exp_prs [$];
  logic [31:0] row_snap;

  // Key model: pressed from the first closed sample until 16 consecutive open samples.
  always @(posedge clk or negedge rst_n) begin
    int k;
    bit old;
    if (!rst_n) begin
      md = 0; mr = 0;
      for (int i = 0; i < NK; i++) begin deb_m[i] = 1'b0; open_run[i] = 16; end
    end else if (!m_scan) begin
      md = 0; mr = 0;
    end else if (md == (1 << DW) - 1) begin
      for (int c = 0; c < NC; c++) begin
        k = mr * NC + c;
        old = deb_m[k];
        if (keys[mr][c]) begin
          open_run[k] = 0; deb_m[k] = 1'b1;
        end else if (open_run[k] < 16) begin
          open_run[k]++;
          if (open_run[k] == 16) deb_m[k] = 1'b0;
        end
        if (m_evt && deb_m[k] != old) begin
          exp_key.push_back(k); exp_prs.push_back(deb_m[k]);
        end
      end
      md = 0; mr = (mr + 1) % NR;
    end else begin
      md++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_row(input int r);
    logic [31:0] w;
    w = '0;
    for (int c = 0; c < NC; c++) w[c] = deb_m[r * NC + c];
    return w;
  endfunction

  task automatic wb_xfer(input logic [3:0] a, input logic we, input logic [31:0] wd,
                         output logic [31:0] rd);
    @(negedge clk);
    if (a >= 4'd8 && a < 4'(8 + NR)) row_snap = model_row(int'(a) - 8);
    wb_addr = a; wb_we = we; wb_wdata = wd; wb_cyc = 1'b1;
    @(posedge clk); #1;
    rd = wb_rdata;
    check("ack_rise", {31'd0, wb_ack}, 32'd1);
    @(posedge clk); #1;
    check("ack_fall", {31'd0, wb_ack}, 32'd0);
    wb_cyc = 1'b0; wb_we = 1'b0;
    if (we && a == 4'd0) begin m_scan = wd[0]; m_evt = wd[1]; end
    $display("wb %s addr=%0d wdata=%h rdata=%h", we ? "wr" : "rd", a, wd, rd);
  endtask

  task automatic read_evt(output logic [31:0] rd);
    int key, idx;
    wb_xfer(4'd2, 1'b0, 32'd0, rd);
    if (rd[31]) begin
      check("evt_fmt", rd & 32'h7FFE_F8E0, 32'd0);
      key = int'(rd[10:8]) * NC + int'(rd[4:0]);
      idx = -1;
      for (int i = 0; i < exp_key.size(); i++)
        if (exp_key[i] == key) begin idx = i; break; end
      if (idx < 0) check("evt_unexpected", rd, 32'd0);
      else begin
        check("evt_dir", {31'd0, rd[16]}, {31'd0, exp_prs[idx]});
        exp_key.delete(idx); exp_prs.delete(idx);
        if (rd[16]) n_press++; else n_rel++;
      end
    end else begin
      check("evt_empty", rd, 32'd0);
    end
  endtask

  task automatic drain(input int limit);
    logic [31:0] rd;
    int tries = 0;
    while (exp_key.size() > 0 && tries < limit) begin
      read_evt(rd);
      if (!rd[31]) repeat (8) @(posedge clk);
      tries++;
    end
    check("drain_left", exp_key.size(), 32'd0);
  endtask

  task automatic wait_deb(input int k, input bit val, input int limit);
    int n = 0;
    while (deb_m[k] != val && n < limit) begin @(negedge clk); n++; end
    check("wait_deb", {31'd0, deb_m[k]}, {31'd0, val});
  endtask

  task automatic check_row_reg(input int r);
    logic [31:0] rd;
    wb_xfer(4'(8 + r), 1'b0, 32'd0, rd);
    check("row_reg", rd, row_snap);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int p0, r0, rr, cc;
    for (int r = 0; r < NR; r++) keys[r] = '0;

    repeat (3) @(posedge clk); #1;
    check("rst_km_row", {28'd0, km_row}, 32'h0000_000E);
    check("rst_ack", {31'd0, wb_ack}, 32'd0);
    check("rst_rdata", wb_rdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk); #1;
      if (i == 15) check("row_t15", {28'd0, km_row}, 32'h0000_000E);
      if (i == 16) check("row_t16", {28'd0, km_row}, 32'h0000_000D);
      if (i == 63) check("row_t63", {28'd0, km_row}, 32'h0000_0007);
      if (i == 64) check("row_t64", {28'd0, km_row}, 32'h0000_000E);
    end
    wb_xfer(4'd0, 1'b0, 32'd0, rd); check("csr_rst", rd, 32'h1);
    wb_xfer(4'd1, 1'b0, 32'd0, rd); check("status_rst", rd, 32'h0001_0000);
    wb_xfer(4'd5, 1'b0, 32'd0, rd); check("unmapped", rd, 32'd0);

    // Single-sample press of (1,3), then release after the hysteresis window.
    wb_xfer(4'd0, 1'b1, 32'h3, rd);
    keys[1][3] = 1'b1;
    wait_deb(15, 1'b1, 300);
    keys[1][3] = 1'b0;
    repeat (60) @(posedge clk);
    check_row_reg(1);
    check("row9_set", row_snap, 32'h8);
    read_evt(rd); check("evt_press13", rd, 32'h8001_0103);
    check("irq_off", {31'd0, irq}, 32'd0);
    wait_deb(15, 1'b0, 1500);
    repeat (60) @(posedge clk);
    read_evt(rd); check("evt_rel13", rd, 32'h8000_0103);
    check_row_reg(1);

    read_evt(rd); check("evt_on_empty", rd, 32'd0);
    wb_xfer(4'd1, 1'b0, 32'd0, rd); check("status_after_empty", rd, 32'h0001_0000);

    // Twelve simultaneous presses overflow a 4-deep queue.
    wb_xfer(4'd0, 1'b1, 32'h7, rd);
    p0 = n_press;
    keys[2] = '1;
    wait_deb(35, 1'b1, 300);
    repeat (100) @(posedge clk); #1;
    check("irq_full", {31'd0, irq}, 32'd1);
    wb_xfer(4'd1, 1'b0, 32'd0, rd); check("status_full", rd, 32'h0102_0004);
    drain(400);
    check("press_count", n_press - p0, 32'd12);
    wb_xfer(4'd1, 1'b0, 32'd0, rd); check("stall_sticky", rd, 32'h0101_0000);
    wb_xfer(4'd1, 1'b1, 32'h0100_0000, rd);
    wb_xfer(4'd1, 1'b0, 32'd0, rd); check("stall_w1c", rd, 32'h0001_0000);
    check("irq_drained", {31'd0, irq}, 32'd0);
    keys[2] = '0;
    wait_deb(35, 1'b0, 1500);
    drain(400);
    wb_xfer(4'd1, 1'b1, 32'h0100_0000, rd);

    // Presses while events are disabled produce no backlog.
    wb_xfer(4'd0, 1'b1, 32'h1, rd);
    keys[0][2:0] = 3'b111;
    wait_deb(2, 1'b1, 300);
    repeat (20) @(posedge clk);
    wb_xfer(4'd0, 1'b1, 32'h3, rd);
    repeat (150) @(posedge clk);
    wb_xfer(4'd1, 1'b0, 32'd0, rd); check("no_backlog", rd, 32'h0001_0000);
    r0 = n_rel;
    keys[0] = '0;
    wait_deb(2, 1'b0, 1500);
    drain(300);
    check("release_count", n_rel - r0, 32'd3);

    // Scan disable freezes state and parks the row drive.
    keys[3][5] = 1'b1;
    wait_deb(41, 1'b1, 300);
    drain(200);
    wb_xfer(4'd0, 1'b1, 32'h2, rd);
    check("scan_off_row", {28'd0, km_row}, 32'h0000_000F);
    keys[3][5] = 1'b0;
    repeat (1000) @(posedge clk); #1;
    check("scan_off_hold", {28'd0, km_row}, 32'h0000_000F);
    check_row_reg(3);
    check("frozen_row11", row_snap, 32'h20);
    wb_xfer(4'd0, 1'b1, 32'h3, rd);
    check("scan_on_row0", {28'd0, km_row}, 32'h0000_000E);

    // Random toggles, each followed by a full drain.
    for (int it = 0; it < 40; it++) begin
      rr = $urandom_range(0, NR - 1);
      cc = $urandom_range(0, NC - 1);
      keys[rr][cc] = ~keys[rr][cc];
      repeat (64 + $urandom_range(0, 63)) @(posedge clk);
      @(negedge clk);
      check("rand_km_row", {28'd0, km_row}, 32'(~(4'b0001 << mr)) & 32'hF);
      drain(300);
      check_row_reg($urandom_range(0, NR - 1));
    end
    for (int r = 0; r < NR; r++) keys[r] = '0;
    repeat (1200) @(posedge clk);
    drain(400);
    repeat (100) @(posedge clk);
    wb_xfer(4'd1, 1'b0, 32'd0, rd);
    check("final_status", rd & 32'h0003_01FF, 32'h0001_0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
